// File: rtl/vnu_serial.sv
// Serial LDPC variable-node unit: collects L, R1..RDV, then emits Q_k = total - R_k.
// Define VNU_SAT_EN to saturate out_data to W bits; otherwise it wraps.
module vnu_serial #(
  parameter int W  = 32,
  parameter int DV = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [W-1:0]                 in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [W-1:0]                 out_data,
  output logic [((DV>1)?$clog2(DV):1)-1:0]    out_idx,
  output logic                                out_last,
  output logic                                p
);

  localparam int IDXW = (DV > 1) ? $clog2(DV) : 1;
  localparam int BW   = $clog2(DV + 1);
  localparam int ACCW = W + BW;

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [IDXW-1:0]        k_q, k_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   p_q, p_d;
  logic signed [W-1:0]    r_q [DV];
  logic signed [W-1:0]    r_d [DV];

  logic signed [ACCW-1:0] in_ext;
  logic [IDXW-1:0]        widx;

  assign in_ext = {{BW{in_data[W-1]}}, in_data};
  // beat n (1..DV) lands in R entry n-1
  assign widx   = IDXW'(beat_q - BW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      beat_q  <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      p_q     <= 1'b0;
      for (int i = 0; i < DV; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      for (int i = 0; i < DV; i++) r_q[i] <= r_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    k_d     = k_q;
    acc_d   = acc_q;
    p_d     = p_q;
    for (int i = 0; i < DV; i++) r_d[i] = r_q[i];
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          if (beat_q == '0) begin
            acc_d = in_ext;
          end else begin
            acc_d       = acc_q + in_ext;
            r_d[widx]   = in_data;
          end
          if (beat_q == BW'(DV)) begin
            state_d = EMIT;
            k_d     = '0;
            p_d     = acc_d[ACCW-1];
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (k_q == IDXW'(DV - 1)) begin
            state_d = COLLECT;
            beat_d  = '0;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == EMIT);
  assign out_idx   = k_q;
  assign out_last  = (state_q == EMIT) && (k_q == IDXW'(DV - 1));
  assign p         = p_q;

`ifdef VNU_SAT_EN
  logic signed [ACCW-1:0] diff;
  logic                   ovf;

  assign diff = acc_q - {{BW{r_q[k_q][W-1]}}, r_q[k_q]};
  // fits in W bits only if the bits above the W-bit sign all match it
  assign ovf  = (|diff[ACCW-1:W-1]) & ~(&diff[ACCW-1:W-1]);

  always_comb begin
    out_data = diff[W-1:0];
    if (ovf) out_data = diff[ACCW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
`else
  assign out_data = acc_q[W-1:0] - r_q[k_q];
`endif

endmodule

// File: tb/tb_vnu_serial.sv
// Directed bench for vnu_serial at W=8, DV=3; expected Q values are hand-computed.
module tb_vnu_serial;

  localparam int W  = 8;
  localparam int DV = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;
  logic [1:0]          out_idx;
  logic                out_last;
  logic                p;

  int n_tests = 0;
  int n_fail  = 0;

  vnu_serial #(.W(W), .DV(DV)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .p(p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // all driving and sampling happens on the falling edge
  task automatic send(input int v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = W'(v);
    while (!in_ready && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) chk("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input int q, input int idx, input int last);
    int n = 0;
    while (!out_valid && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_data"}, out_data, q);
    chk({tag, "_idx"},  out_idx, idx);
    chk({tag, "_last"}, out_last, last);
    @(negedge clk);
  endtask

  task automatic frame(input string tag, input int l, input int r0, input int r1, input int r2,
                       input int q0, input int q1, input int q2, input int pe);
    send(l); send(r0); send(r1); send(r2);
    chk({tag, "_lat"}, out_valid, 1);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_p"}, p, pe);
    recv({tag, "_q0"}, q0, 0, 0);
    recv({tag, "_q1"}, q1, 1, 0);
    recv({tag, "_q2"}, q2, 2, 1);
    chk({tag, "_back"}, in_ready, 1);
  endtask

  int stream [8] = '{10, 20, -5, 7, 1, 2, 3, 4};
  int expq   [6] = '{12, 37, 25, 8, 7, 6};

  initial begin
    int ptr, oi;
    logic last_seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_data", out_data, 0);
    reset = 1'b0;
    @(negedge clk);

    frame("f1", 10, 20, -5, 7, 12, 37, 25, 0);
`ifdef VNU_SAT_EN
    frame("f2", 100, 100, 100, -1, 127, 127, 127, 0);
    frame("f3", -50, -60, -70, 10, -110, -100, -128, 1);
`else
    frame("f2", 100, 100, 100, -1, -57, -57, 44, 0);
    frame("f3", -50, -60, -70, 10, -110, -100, 76, 1);
`endif

    // p holds through the next collect; stall at idx 1
    send(10);
    chk("p_hold", p, 1);
    send(20); send(-5); send(7);
    chk("st_p", p, 0);
    recv("st_q0", 12, 0, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'sd99;
    for (int i = 0; i < 3; i++) begin
      chk("st_hold_data", out_data, 37);
      chk("st_hold_idx", out_idx, 1);
      chk("st_hold_vld", out_valid, 1);
      chk("st_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    recv("st_q1", 37, 1, 0);
    recv("st_q2", 25, 2, 1);

    // reset after two beats of a collect
    send(5); send(6);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_out_valid", out_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    frame("fr", 1, 2, 3, 4, 8, 7, 6, 0);

    // reset during emit
    send(1); send(2); send(3); send(4);
    recv("me_q0", 8, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("me_out_valid", out_valid, 0);
    chk("me_p", p, 0);
    reset = 1'b0;
    @(negedge clk);
    frame("fe", -50, -60, -70, 10, -110, -100,
`ifdef VNU_SAT_EN
          -128,
`else
          76,
`endif
          1);

    // back-to-back frames with in_valid held high
    ptr = 0; oi = 0; last_seen = 1'b0;
    for (int c = 0; c < 40 && (ptr < 8 || oi < 6); c++) begin
      in_valid = (ptr < 8);
      in_data  = (ptr < 8) ? W'(stream[ptr]) : '0;
      if (last_seen && ptr < 8) chk("b2b_accept_next", in_ready, 1);
      last_seen = 1'b0;
      chk("b2b_no_overlap", int'(in_ready && out_valid), 0);
      if (in_ready && in_valid) ptr++;
      if (out_valid) begin
        chk("b2b_q", out_data, (oi < 6) ? expq[oi] : -999);
        last_seen = out_last;
        oi++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_beats", ptr, 8);
    chk("b2b_msgs", oi, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
